// File: rtl/riscv_cache_tag_pipe.sv
// Elastic DEPTH-stage request pipeline between cache setup and hit/line-select.
// Per-stage valid/ready handshake collapses bubbles; also provides a line-granular in-flight compare and an occupancy count.
module riscv_cache_tag_pipe #(
  parameter int XLEN      = 32,
  parameter int PLEN      = XLEN,
  parameter int DEPTH     = 2,
  parameter int LINE_SIZE = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,

  input  logic                         req_i,
  output logic                         req_ready_o,
  input  logic [PLEN-1:0]              adr_i,
  input  logic [2:0]                   size_i,
  input  logic                         lock_i,
  input  logic [2:0]                   prot_i,
  input  logic                         is_cacheable_i,
  input  logic                         is_misaligned_i,

  output logic                         req_o,
  input  logic                         ready_i,
  output logic [PLEN-1:0]              adr_o,
  output logic [2:0]                   size_o,
  output logic                         lock_o,
  output logic [2:0]                   prot_o,
  output logic                         is_cacheable_o,
  output logic                         is_misaligned_o,

  input  logic [PLEN-1:0]              cmp_adr_i,
  output logic                         cmp_hit_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

  localparam int OFS = $clog2(LINE_SIZE);
  localparam int CW  = $clog2(DEPTH+1);

  typedef struct packed {
    logic [PLEN-1:0] adr;
    logic [2:0]      size;
    logic            lock;
    logic [2:0]      prot;
    logic            cacheable;
    logic            misaligned;
  } pay_t;

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] adv;
  pay_t             pay_q [DEPTH];
  pay_t             pay_in;
  logic             accept;
  logic             xfer;
  logic [CW-1:0]    occ_q;

  assign pay_in = '{adr: adr_i, size: size_i, lock: lock_i, prot: prot_i,
                    cacheable: is_cacheable_i, misaligned: is_misaligned_i};

  // Advance chain is walked from the output stage back through a local
  // carry so no bit of adv depends on another bit of the same vector.
  always_comb begin
    logic a;
    adv = '0;
    a = v_q[DEPTH-1] & ready_i;
    adv[DEPTH-1] = a;
    for (int unsigned j = 1; j < DEPTH; j++) begin
      a = v_q[DEPTH-1-j] & (~v_q[DEPTH-j] | a);
      adv[DEPTH-1-j] = a;
    end
  end

  assign req_ready_o = ~v_q[0] | adv[0];
  assign accept      = req_i & req_ready_o;
  assign xfer        = adv[DEPTH-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q <= '0;
    end else if (flush_i) begin
      v_q <= '0;
    end else begin
      v_q[0] <= accept | (v_q[0] & ~adv[0]);
      for (int unsigned k = 1; k < DEPTH; k++) begin
        v_q[k] <= adv[k-1] | (v_q[k] & ~adv[k]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) pay_q[0] <= pay_in;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      if (adv[k-1]) pay_q[k] <= pay_q[k-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q <= '0;
    end else if (flush_i) begin
      occ_q <= '0;
    end else if (accept && !xfer) begin
      occ_q <= occ_q + 1'b1;
    end else if (!accept && xfer) begin
      occ_q <= occ_q - 1'b1;
    end
  end

  always_comb begin
    cmp_hit_o = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (v_q[k] && (pay_q[k].adr[PLEN-1:OFS] == cmp_adr_i[PLEN-1:OFS])) cmp_hit_o = 1'b1;
    end
  end

  assign occupancy_o     = occ_q;
  assign req_o           = v_q[DEPTH-1];
  assign adr_o           = pay_q[DEPTH-1].adr;
  assign size_o          = pay_q[DEPTH-1].size;
  assign lock_o          = pay_q[DEPTH-1].lock;
  assign prot_o          = pay_q[DEPTH-1].prot;
  assign is_cacheable_o  = pay_q[DEPTH-1].cacheable;
  assign is_misaligned_o = pay_q[DEPTH-1].misaligned;

endmodule
